// File: rtl/rename_unit.sv
// Register rename stage: speculative RAT plus circular free list, fed back by ROB commit/rollback.
// Define RENAME_FREECNT_EN to expose the live free-list count (fl_count) and a sticky error flag (fl_err).
module rename_unit #(
   parameter int NUM_AREG = 64,
   parameter int NUM_PREG = 128,
   parameter int FL_DEPTH = NUM_PREG - NUM_AREG
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [5:0] in_A_rs1,
   input  logic [5:0] in_A_rs2,
   input  logic [5:0] in_A_rd,
   input  logic       in_rd_wen,
   input  logic       rob_ready,
   input  logic       stall,
   output logic       rename_ready,
   output logic       out_valid,
   output logic [6:0] out_P_rs1,
   output logic [6:0] out_P_rs2,
   output logic [6:0] out_P_rd_new,
   output logic [6:0] out_P_rd_old,
   output logic [5:0] out_A_rd,
`ifdef RENAME_FREECNT_EN
   output logic [6:0] fl_count,
   output logic       fl_err,
`endif
   input  logic       commit_wb_en,
   input  logic [6:0] commit_P_rd_old,
   input  logic       rollback_en_0,
   input  logic [5:0] rollback_A_rd_0,
   input  logic [6:0] rollback_P_rd_old_0,
   input  logic [6:0] rollback_P_rd_new_0,
   input  logic       rollback_en_1,
   input  logic [5:0] rollback_A_rd_1,
   input  logic [6:0] rollback_P_rd_old_1,
   input  logic [6:0] rollback_P_rd_new_1
);

   localparam int PW = 7;
   localparam int HW = $clog2(FL_DEPTH);
   localparam int CW = $clog2(FL_DEPTH + 1);

   logic [PW-1:0] rat       [NUM_AREG];
   logic [PW-1:0] free_list [FL_DEPTH];
   logic [HW-1:0] head;
   logic [HW-1:0] tail;
   logic [CW-1:0] count;

   logic          alloc;
   logic          fire;
   logic          pop;
   logic          req_c, req_r0, req_r1;
   logic          acc_c, acc_r0, acc_r1;
   logic          rb0_wr, rb1_wr;
   logic [CW:0]   space;
   logic [1:0]    npush;
   logic [HW-1:0] slot_r0, slot_r1, tail_next, head_next;
   logic [CW-1:0] count_next;

   function automatic logic [HW-1:0] wrap_add(input logic [HW-1:0] ptr, input logic [1:0] n);
      logic [HW+1:0] sum;
      sum = {2'b00, ptr} + {{HW{1'b0}}, n};
      if (sum >= (HW+2)'(FL_DEPTH)) sum = sum - (HW+2)'(FL_DEPTH);
      return sum[HW-1:0];
   endfunction

   // Rename handshake and combinational lookups read the RAT before this cycle's update
   always_comb begin
      alloc        = in_rd_wen && (in_A_rd != 6'd0);
      rename_ready = rob_ready && !stall && (!alloc || (count != '0));
      fire         = in_valid && rename_ready;
      pop          = fire && alloc;
      out_valid    = fire;
      out_P_rs1    = rat[in_A_rs1];
      out_P_rs2    = rat[in_A_rs2];
      out_P_rd_new = alloc ? free_list[head] : '0;
      out_P_rd_old = alloc ? rat[in_A_rd] : '0;
      out_A_rd     = in_A_rd;
   end

   // Pushes are granted in priority commit, rollback_0, rollback_1 until the list is full;
   // anything beyond the remaining space is dropped so count can never exceed FL_DEPTH.
   always_comb begin
      req_c  = commit_wb_en && (commit_P_rd_old != '0);
      req_r0 = rollback_en_0 && (rollback_P_rd_new_0 != '0);
      req_r1 = rollback_en_1 && (rollback_P_rd_new_1 != '0);
      rb0_wr = req_r0 && (rollback_A_rd_0 != 6'd0);
      rb1_wr = req_r1 && (rollback_A_rd_1 != 6'd0);
      space  = (CW+1)'(FL_DEPTH) - {1'b0, count} + (CW+1)'(pop);
      acc_c  = req_c && (space > (CW+1)'(0));
      acc_r0 = req_r0 && (space > (CW+1)'(acc_c));
      acc_r1 = req_r1 && (space > ((CW+1)'(acc_c) + (CW+1)'(acc_r0)));
      npush  = {1'b0, acc_c} + {1'b0, acc_r0} + {1'b0, acc_r1};
      slot_r0    = wrap_add(tail, {1'b0, acc_c});
      slot_r1    = wrap_add(tail, {1'b0, acc_c} + {1'b0, acc_r0});
      tail_next  = wrap_add(tail, npush);
      head_next  = wrap_add(head, 2'd1);
      count_next = count + CW'(npush) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_AREG; i++) rat[i] <= PW'(i);
         for (int j = 0; j < FL_DEPTH; j++) free_list[j] <= PW'(NUM_AREG + j);
         head  <= '0;
         tail  <= '0;
         count <= CW'(FL_DEPTH);
      end else begin
         if (pop) begin
            rat[in_A_rd] <= free_list[head];
            head         <= head_next;
         end
         // Port 1 is older, so its restore lands last and wins on a shared A_rd
         if (rb0_wr) rat[rollback_A_rd_0] <= rollback_P_rd_old_0;
         if (rb1_wr) rat[rollback_A_rd_1] <= rollback_P_rd_old_1;
         if (acc_c)  free_list[tail]    <= commit_P_rd_old;
         if (acc_r0) free_list[slot_r0] <= rollback_P_rd_new_0;
         if (acc_r1) free_list[slot_r1] <= rollback_P_rd_new_1;
         tail  <= tail_next;
         count <= count_next;
      end
   end

`ifdef RENAME_FREECNT_EN
   logic ovf_attempt;
   logic pop_empty;
   logic push_p0;

   // A rollback entry that names a real destination but a zero new mapping would free P0
   always_comb begin
      ovf_attempt = ((CW+1)'(req_c) + (CW+1)'(req_r0) + (CW+1)'(req_r1)) > space;
      pop_empty   = pop && (count == '0);
      push_p0     = (rollback_en_0 && (rollback_A_rd_0 != 6'd0) && (rollback_P_rd_new_0 == '0)) ||
                    (rollback_en_1 && (rollback_A_rd_1 != 6'd0) && (rollback_P_rd_new_1 == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) fl_err <= 1'b0;
      else if (ovf_attempt || pop_empty || push_p0) fl_err <= 1'b1;
   end

   assign fl_count = count;
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: directed renames, commit, exhaustion, rollback and reset-in-recovery.
// Optional-feature checks are compiled in when RENAME_FREECNT_EN is defined.
module tb_rename_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_rd_wen, rob_ready, stall;
   logic [5:0] in_A_rs1, in_A_rs2, in_A_rd;
   logic       rename_ready, out_valid;
   logic [6:0] out_P_rs1, out_P_rs2, out_P_rd_new, out_P_rd_old;
   logic [5:0] out_A_rd;
   logic       commit_wb_en;
   logic [6:0] commit_P_rd_old;
   logic       rollback_en_0, rollback_en_1;
   logic [5:0] rollback_A_rd_0, rollback_A_rd_1;
   logic [6:0] rollback_P_rd_old_0, rollback_P_rd_new_0, rollback_P_rd_old_1, rollback_P_rd_new_1;
`ifdef RENAME_FREECNT_EN
   logic [6:0] fl_count;
   logic       fl_err;
`endif

   rename_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_A_rs1(in_A_rs1), .in_A_rs2(in_A_rs2),
      .in_A_rd(in_A_rd), .in_rd_wen(in_rd_wen), .rob_ready(rob_ready), .stall(stall),
      .rename_ready(rename_ready), .out_valid(out_valid), .out_P_rs1(out_P_rs1),
      .out_P_rs2(out_P_rs2), .out_P_rd_new(out_P_rd_new), .out_P_rd_old(out_P_rd_old),
      .out_A_rd(out_A_rd),
`ifdef RENAME_FREECNT_EN
      .fl_count(fl_count), .fl_err(fl_err),
`endif
      .commit_wb_en(commit_wb_en), .commit_P_rd_old(commit_P_rd_old),
      .rollback_en_0(rollback_en_0), .rollback_A_rd_0(rollback_A_rd_0),
      .rollback_P_rd_old_0(rollback_P_rd_old_0), .rollback_P_rd_new_0(rollback_P_rd_new_0),
      .rollback_en_1(rollback_en_1), .rollback_A_rd_1(rollback_A_rd_1),
      .rollback_P_rd_old_1(rollback_P_rd_old_1), .rollback_P_rd_new_1(rollback_P_rd_new_1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] rs1;
      logic [6:0] rs2;
      logic [6:0] nw;
      logic [6:0] old;
      logic [5:0] ard;
   } exp_t;

   exp_t expQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every dispatch fire is matched against the oldest expected rename
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_fire", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("P_rs1", 32'(out_P_rs1), 32'(e.rs1));
            checkOutput("P_rs2", 32'(out_P_rs2), 32'(e.rs2));
            checkOutput("P_rd_new", 32'(out_P_rd_new), 32'(e.nw));
            checkOutput("P_rd_old", 32'(out_P_rd_old), 32'(e.old));
            checkOutput("A_rd", 32'(out_A_rd), 32'(e.ard));
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearSide();
      commit_wb_en = 0; commit_P_rd_old = 0;
      rollback_en_0 = 0; rollback_A_rd_0 = 0; rollback_P_rd_old_0 = 0; rollback_P_rd_new_0 = 0;
      rollback_en_1 = 0; rollback_A_rd_1 = 0; rollback_P_rd_old_1 = 0; rollback_P_rd_new_1 = 0;
   endtask

   // Drive one instruction for one cycle and queue the rename it should produce
   task automatic applyStimulus(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                                input logic wen, input logic [6:0] eRs1, input logic [6:0] eRs2,
                                input logic [6:0] eNew, input logic [6:0] eOld);
      exp_t e;
      in_valid = 1; in_A_rs1 = rs1; in_A_rs2 = rs2; in_A_rd = rd; in_rd_wen = wen;
      e.rs1 = eRs1; e.rs2 = eRs2; e.nw = eNew; e.old = eOld; e.ard = rd;
      expQ.push_back(e);
      cycle();
   endtask

   task automatic idle();
      in_valid = 0; in_rd_wen = 0;
      cycle();
   endtask

   initial begin
      logic [6:0] prev;
      logic [6:0] nw;
      rst = 1; in_valid = 0; in_rd_wen = 0; in_A_rs1 = 0; in_A_rs2 = 0; in_A_rd = 0;
      rob_ready = 1; stall = 0;
      clearSide();
      repeat (2) @(posedge clk);
      #1 rst = 0;

      checkOutput("ready_after_reset", 32'(rename_ready), 32'd1);
      rob_ready = 0; #1;
      checkOutput("ready_rob_full", 32'(rename_ready), 32'd0);
      rob_ready = 1; stall = 1; #1;
      checkOutput("ready_stall", 32'(rename_ready), 32'd0);
      stall = 0;

      applyStimulus(6'd1, 6'd2, 6'd5, 1'b1, 7'd1, 7'd2, 7'd64, 7'd5);
      applyStimulus(6'd5, 6'd0, 6'd6, 1'b1, 7'd64, 7'd0, 7'd65, 7'd6);
      applyStimulus(6'd5, 6'd6, 6'd9, 1'b0, 7'd64, 7'd65, 7'd0, 7'd0);
      in_valid = 0; in_rd_wen = 0;
      commit_wb_en = 1; commit_P_rd_old = 7'd5;
      cycle();
      clearSide();

      // Drain: slots 2..63 hold P66..P127, slot 0 now holds the committed P5
      prev = 7'd10;
      for (int i = 0; i < 63; i++) begin
         nw = (i < 62) ? 7'(66 + i) : 7'd5;
         applyStimulus(6'd10, 6'd0, 6'd10, 1'b1, prev, 7'd0, nw, prev);
         prev = nw;
      end
      in_valid = 1; in_A_rd = 6'd11; in_rd_wen = 1; #1;
      checkOutput("ready_empty_alloc", 32'(rename_ready), 32'd0);
      cycle();
      applyStimulus(6'd10, 6'd5, 6'd3, 1'b0, 7'd5, 7'd64, 7'd0, 7'd0);
      applyStimulus(6'd0, 6'd0, 6'd0, 1'b1, 7'd0, 7'd0, 7'd0, 7'd0);

      // Same-cycle rollback on A_rd=7 while stalled; port 1 must win
      in_valid = 1; in_A_rd = 6'd11; in_rd_wen = 1; stall = 1;
      rollback_en_0 = 1; rollback_A_rd_0 = 6'd7; rollback_P_rd_old_0 = 7'd70; rollback_P_rd_new_0 = 7'd71;
      rollback_en_1 = 1; rollback_A_rd_1 = 6'd7; rollback_P_rd_old_1 = 7'd7;  rollback_P_rd_new_1 = 7'd70;
      #1;
      checkOutput("ready_during_stall", 32'(rename_ready), 32'd0);
      cycle();
      clearSide(); stall = 0;
      applyStimulus(6'd7, 6'd5, 6'd7, 1'b1, 7'd7, 7'd64, 7'd71, 7'd7);
      applyStimulus(6'd7, 6'd0, 6'd8, 1'b1, 7'd71, 7'd0, 7'd70, 7'd8);
      in_valid = 1; in_A_rd = 6'd12; in_rd_wen = 1; #1;
      checkOutput("ready_empty_again", 32'(rename_ready), 32'd0);
      cycle();

      // Reset in the middle of a recovery restores the reset mapping
      in_valid = 0; stall = 1; rst = 1;
      rollback_en_0 = 1; rollback_A_rd_0 = 6'd5; rollback_P_rd_old_0 = 7'd99; rollback_P_rd_new_0 = 7'd100;
      cycle();
      rst = 0; stall = 0; clearSide();
      applyStimulus(6'd10, 6'd7, 6'd5, 1'b1, 7'd10, 7'd7, 7'd64, 7'd5);

`ifdef RENAME_FREECNT_EN
      applyStimulus(6'd5, 6'd0, 6'd6, 1'b1, 7'd64, 7'd0, 7'd65, 7'd6);
      in_valid = 0; in_rd_wen = 0; #1;
      checkOutput("fl_count_62", 32'(fl_count), 32'd62);
      checkOutput("fl_err_clear", 32'(fl_err), 32'd0);
      stall = 1;
      commit_wb_en = 1; commit_P_rd_old = 7'd20;
      rollback_en_0 = 1; rollback_A_rd_0 = 6'd5; rollback_P_rd_old_0 = 7'd5; rollback_P_rd_new_0 = 7'd64;
      rollback_en_1 = 1; rollback_A_rd_1 = 6'd6; rollback_P_rd_old_1 = 7'd6; rollback_P_rd_new_1 = 7'd65;
      cycle();
      clearSide(); stall = 0;
      checkOutput("fl_count_sat", 32'(fl_count), 32'd64);
      checkOutput("fl_err_set", 32'(fl_err), 32'd1);
      cycle();
      checkOutput("fl_err_sticky", 32'(fl_err), 32'd1);
      rst = 1; cycle(); rst = 0; #1;
      checkOutput("fl_err_rst", 32'(fl_err), 32'd0);
      checkOutput("fl_count_rst", 32'(fl_count), 32'd64);
`endif

      idle();
      for (int k = 0; k < 20 && expQ.size() != 0; k++) cycle();
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register rename stage directly upstream of the reorder buffer: maps 6-bit architectural registers (0-31 int, 32-63 fp) to 7-bit physical registers, one instruction per cycle.
- Produces the P_rd_new/P_rd_old/A_rd triple that is dispatched into the ROB.
- Consumes the ROB's commit port to free old mappings and its two rollback ports to undo speculative mappings after a mispredict.
- Holds the speculative RAT and a circular free list.

Parameters:
- NUM_AREG, 64, architectural registers; index 0 is hardwired zero.
- NUM_PREG, 128, physical registers; P0 is hardwired zero.
- FL_DEPTH, NUM_PREG-NUM_AREG (64), free-list capacity.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_A_rs1  in  6  architectural source 1
- in_A_rs2  in  6  architectural source 2
- in_A_rd  in  6  architectural destination
- in_rd_wen  in  1  instruction writes a destination
- rob_ready  in  1  ROB has a free slot
- stall  in  1  ROB recovery in progress
- rename_ready  out  1  rename accepted this cycle when in_valid=1
- out_valid  out  1  in_valid && rename_ready (dispatch fire)
- out_P_rs1  out  7  physical source 1
- out_P_rs2  out  7  physical source 2
- out_P_rd_new  out  7  allocated destination, 0 if none
- out_P_rd_old  out  7  previous mapping of A_rd, 0 if none
- out_A_rd  out  6  pass-through destination
- commit_wb_en  in  1  commit frees commit_P_rd_old
- commit_P_rd_old  in  7  physical register to free
- rollback_en_0 / rollback_A_rd_0 / rollback_P_rd_old_0 / rollback_P_rd_new_0  in  1/6/7/7  youngest undo entry
- rollback_en_1 / rollback_A_rd_1 / rollback_P_rd_old_1 / rollback_P_rd_new_1  in  1/6/7/7  next-older undo entry

Behaviour:
- Reset: RAT[i]=i for all i; free list holds P64..P127 in order; head=0, tail=0, count=64. Outputs are combinational; after reset rename_ready=rob_ready && !stall.
- alloc = in_rd_wen && in_A_rd!=0.
- rename_ready = rob_ready && !stall && (!alloc || count!=0).
- Sources: out_P_rs1=RAT[in_A_rs1] and out_P_rs2=RAT[in_A_rs2], read combinationally before this cycle's update. A_rs=0 gives P0.
- Destination when alloc: out_P_rd_new=freelist[head]; out_P_rd_old=RAT[in_A_rd]. Otherwise both outputs are 0.
- On fire with alloc, at the next edge: RAT[in_A_rd] <= P_rd_new; head++ (wraps at FL_DEPTH-1); count--.
- Commit push: if commit_wb_en && commit_P_rd_old!=0, push commit_P_rd_old.
- Rollback push: for each k in {0,1}, if rollback_en_k && rollback_P_rd_new_k!=0:
  - restore RAT[rollback_A_rd_k] <= rollback_P_rd_old_k;
  - push rollback_P_rd_new_k.
- Rollback ordering: port 1 is older, so its RAT restore is applied after port 0. If both name the same A_rd, the final value is rollback_P_rd_old_1.
- Push order per cycle: commit, rollback_0, rollback_1. Up to 3 pushes go into consecutive tail slots; tail advances by the number pushed, modulo FL_DEPTH.
- count_next = count + pushes - pop. Width is clog2(FL_DEPTH+1). A pop and pushes in the same cycle are legal.
- Empty: count=0 with alloc deasserts rename_ready. Non-alloc instructions still fire.
- Overflow (count_next>FL_DEPTH) cannot occur under a correct ROB. The push is dropped and count saturates.
- Rename never fires while stall=1, so RAT rename writes and rollback writes never collide.
- Reset asserted mid-recovery restores the full reset state on the next edge.

Optional Feature:
- Macro RENAME_FREECNT_EN.
- Defined:
  - adds output fl_count [6:0] (live count);
  - adds output fl_err [0:0], sticky and cleared only by rst;
  - fl_err sets on attempted overflow, on a pop with count=0, or on a push of P0.
- Undefined: neither port exists and no error logic is generated; all other behaviour is identical.

Test Plan:
- Reset, then rename add x5 (A_rd=5, alloc) -> P_rd_new=64, P_rd_old=5; next cycle RAT[5]=64, count=63.
- Back-to-back x5 then x6 reading x5 -> second instruction gets P_rs1=64, P_rd_new=65, P_rd_old=6.
- Commit with commit_P_rd_old=5 -> P5 is written at tail slot 0; count goes 62 to 63.
- 64 consecutive allocs with no commits -> count=0 and rename_ready=0 for an alloc; a store (in_rd_wen=0) still fires with P_rd_new=0.
- Same-cycle rollback, both ports valid on A_rd=7 (port 0: old=70/new=71; port 1: old=7/new=70) -> RAT[7]=7, P71 and P70 pushed, count+=2.
- With RENAME_FREECNT_EN defined, a commit push plus two rollback pushes at count=62 -> count saturates at 64, the excess is dropped, and fl_err=1 until rst.
